// File: rtl/mem_responder.sv
module mem_responder #(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        memory_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        data_valid,
  output logic        write_done,
  output logic        busy,
  output logic        misaligned
);

  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
  localparam logic [3:0]  WAIT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    RESPOND
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [31:0]          read_data_q, read_data_d;
  logic                 write_done_q, write_done_d;
  logic                 misaligned_q, misaligned_d;

  logic [ADDR_BITS-1:0] req_idx;
  logic [ADDR_BITS-1:0] rd_idx;
  logic                 accept;
  logic                 mem_we;
  logic                 load_rd;
  logic                 unused_addr_bits;

  logic [31:0] mem_q [DEPTH];

  assign req_idx          = address[ADDR_BITS+1:2];
  assign unused_addr_bits = ^address[31:ADDR_BITS+2];

  // RESPOND accepts a new request exactly like IDLE, so both share one branch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    read_data_d  = read_data_q;
    write_done_d = 1'b0;
    misaligned_d = misaligned_q;
    accept       = 1'b0;
    mem_we       = 1'b0;
    load_rd      = 1'b0;
    rd_idx       = idx_q;

    case (state_q)
      IDLE, RESPOND: begin
        state_d = IDLE;
        if (mem_req) begin
          accept = 1'b1;
          if (memory_write) begin
            mem_we       = 1'b1;
            write_done_d = 1'b1;
          end else begin
            idx_d = req_idx;
            cnt_d = WAIT_INIT;
            if (READ_LATENCY == 1) begin
              state_d = RESPOND;
              load_rd = 1'b1;
              rd_idx  = req_idx;
            end else begin
              state_d = READ_WAIT;
            end
          end
        end
      end
      READ_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESPOND;
          load_rd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept && (address[1:0] != 2'b00)) begin
      misaligned_d = 1'b1;
    end
    if (load_rd) begin
      read_data_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      read_data_q  <= '0;
      write_done_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      read_data_q  <= read_data_d;
      write_done_q <= write_done_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Storage is never cleared; reset only blocks a write on its own edge.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[req_idx] <= write_data;
    end
  end

  assign read_data  = read_data_q;
  assign data_valid = (state_q == RESPOND);
  assign write_done = write_done_q;
  assign busy       = (state_q == READ_WAIT);
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int unsigned AB  = 8;
  localparam int unsigned LAT = 3;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        data_valid;
  logic        write_done;
  logic        busy;
  logic        misaligned;

  int          checks;
  int          errors;
  int          dv_count;
  int          reads_issued;
  bit          mon_en;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  mem_responder #(
    .ADDR_BITS   (AB),
    .READ_LATENCY(LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .memory_write(memory_write),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .data_valid  (data_valid),
    .write_done  (write_done),
    .busy        (busy),
    .misaligned  (misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("dv_wd_exclusive", {31'b0, data_valid & write_done}, 32'd0);
      if (data_valid === 1'b1) begin
        dv_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dv_unexpected: got data_valid=1 read_data=0x%h, expected no response at %0t",
                   read_data, $time);
        end else begin
          chk("read_data", read_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    mem_req      = 1'b1;
    memory_write = 1'b1;
    address      = a;
    write_data   = d;
    @(posedge clock);
    #1;
    mem_req = 1'b0;
    @(negedge clock);
    chk("write_done_pulse", {31'b0, write_done}, 32'd1);
    chk("busy_on_write", {31'b0, busy}, 32'd0);
    @(negedge clock);
    chk("write_done_end", {31'b0, write_done}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input bit hold);
    int k;
    bit got;
    @(negedge clock);
    mem_req      = 1'b1;
    memory_write = 1'b0;
    address      = a;
    @(posedge clock);
    #1;
    if (!hold) mem_req = 1'b0;
    exp_q.push_back(exp);
    reads_issued++;
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clock);
      k++;
      if (data_valid === 1'b1) got = 1'b1;
      else chk("busy_wait", {31'b0, busy}, 32'd1);
    end
    mem_req = 1'b0;
    chk("read_latency", got ? k : 99, LAT);
    chk("busy_respond", {31'b0, busy}, 32'd0);
    @(negedge clock);
    chk("dv_single", {31'b0, data_valid}, 32'd0);
    chk("read_data_held", read_data, exp);
  endtask

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'h1111_1111};
    vecs[3] = '{1'b1, 32'h0000_0400, 32'h2222_2222};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h2222_2222};
    vecs[5] = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5};
    vecs[6] = '{1'b0, 32'hFFFF_F3FC, 32'hA5A5_A5A5};
    vecs[7] = '{1'b1, 32'h0000_0008, 32'h1234_5678};
    vecs[8] = '{1'b0, 32'h0000_0008, 32'h1234_5678};
    vecs[9] = '{1'b0, 32'h0000_0400, 32'h2222_2222};

    checks       = 0;
    errors       = 0;
    dv_count     = 0;
    reads_issued = 0;
    mon_en       = 1'b0;
    reset        = 1'b1;
    mem_req      = 1'b0;
    memory_write = 1'b0;
    address      = '0;
    write_data   = '0;

    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_data_valid", {31'b0, data_valid}, 32'd0);
    chk("rst_write_done", {31'b0, write_done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
      else            do_read(vecs[i].addr, vecs[i].data, 1'b0);
    end
    chk("aligned_no_misaligned", {31'b0, misaligned}, 32'd0);

    // Request held through the busy window: one acceptance, one response.
    do_read(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    repeat (LAT + 1) @(negedge clock);
    chk("hold_dv_count", dv_count, reads_issued);

    do_read(32'h0000_0013, 32'hDEAD_BEEF, 1'b0);
    chk("misaligned_set", {31'b0, misaligned}, 32'd1);
    do_read(32'h0000_0008, 32'h1234_5678, 1'b0);
    chk("misaligned_sticky", {31'b0, misaligned}, 32'd1);

    // Reset mid-wait, with a write presented on the reset edge.
    @(negedge clock);
    mem_req      = 1'b1;
    memory_write = 1'b0;
    address      = 32'h0000_0008;
    @(posedge clock);
    #1;
    mem_req = 1'b0;
    @(negedge clock);
    chk("busy_pre_reset", {31'b0, busy}, 32'd1);
    reset        = 1'b1;
    mem_req      = 1'b1;
    memory_write = 1'b1;
    write_data   = 32'hBADB_AD00;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    mem_req = 1'b0;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      @(negedge clock);
      chk("mid_rst_data_valid", {31'b0, data_valid}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    end
    chk("mid_rst_read_data", read_data, 32'd0);
    chk("mid_rst_misaligned", {31'b0, misaligned}, 32'd0);
    chk("mid_rst_write_done", {31'b0, write_done}, 32'd0);
    do_read(32'h0000_0008, 32'h1234_5678, 1'b0);
    do_read(32'h0000_0400, 32'h2222_2222, 1'b0);

    repeat (LAT + 2) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("dv_total", dv_count, reads_issued);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
